dot_int_acc: RTL and testbench

DOT_INT_ACC -- requirements
Module: dot_int_acc

---
 rtl/dot_int_acc.sv | 127 ++++++++++++
 tb/tb_dot_int_acc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_int_acc.sv
// Pipelined signed integer dot-product with per-group accumulation and output handshake.
// Define DOT_INT_ACC_SAT_EN to saturate the accumulator on overflow; otherwise it wraps.
module dot_int_acc #(
  parameter  int bit_width = 8,
  parameter  int k         = 32,
  parameter  int acc_ext   = 8,
  localparam int sum_width = 2*bit_width + $clog2(k),
  localparam int acc_width = sum_width + acc_ext
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [k-1:0][bit_width-1:0]   i_vec_a,
  input  logic [k-1:0][bit_width-1:0]   i_vec_b,
  input  logic                          i_valid,
  input  logic                          i_last,
  output logic                          i_ready,
  output logic signed [acc_width-1:0]   o_acc,
  output logic [15:0]                   o_cnt,
  output logic                          o_ovf,
  output logic                          o_valid,
  input  logic                          o_ready
);

  localparam int prod_width = 2*bit_width;
`ifdef DOT_INT_ACC_SAT_EN
  localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};
`endif

  logic stall;
  assign stall   = o_valid && !o_ready;
  assign i_ready = !stall;

  // S1: element-wise signed products
  logic signed [prod_width-1:0] prod_c  [k];
  logic signed [prod_width-1:0] s1_prod [k];
  logic                         s1_valid;
  logic                         s1_last;

  always_comb begin
    for (int unsigned j = 0; j < k; j++) begin
      prod_c[j] = prod_width'($signed(i_vec_a[j])) * prod_width'($signed(i_vec_b[j]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '{default: '0};
    end else if (!stall) begin
      s1_valid <= i_valid;
      s1_last  <= i_valid && i_last;
      s1_prod  <= prod_c;
    end
  end

  // S2: exact sum of the products
  logic signed [sum_width-1:0] sum_c;
  logic signed [sum_width-1:0] s2_sum;
  logic                        s2_valid;
  logic                        s2_last;

  always_comb begin
    sum_c = '0;
    for (int unsigned j = 0; j < k; j++) begin
      sum_c = sum_c + sum_width'(s1_prod[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;
    end
  end

  // S3: accumulator; o_acc/o_cnt/o_ovf are the accumulator registers themselves
  logic signed [acc_width-1:0] addend;
  logic signed [acc_width-1:0] add_res;
  logic                        add_ovf;
  logic                        grp_open;

  always_comb begin
    addend  = acc_width'(s2_sum);
    add_res = o_acc + addend;
    add_ovf = (o_acc[acc_width-1] == addend[acc_width-1]) &&
              (add_res[acc_width-1] != o_acc[acc_width-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_acc    <= '0;
      o_cnt    <= '0;
      o_ovf    <= 1'b0;
      o_valid  <= 1'b0;
      grp_open <= 1'b0;
    end else if (!stall) begin
      o_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        grp_open <= !s2_last;
        if (!grp_open) begin
          o_acc <= addend;
          o_cnt <= 16'd1;
          o_ovf <= 1'b0;
        end else begin
          o_cnt <= (o_cnt == '1) ? o_cnt : o_cnt + 16'd1;
          o_ovf <= o_ovf | add_ovf;
`ifdef DOT_INT_ACC_SAT_EN
          // once clamped, the group result stays pinned at the rail
          if (o_ovf)        o_acc <= o_acc;
          else if (add_ovf) o_acc <= o_acc[acc_width-1] ? acc_min : acc_max;
          else              o_acc <= add_res;
`else
          o_acc <= add_res;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_int_acc.sv
// Scoreboard bench for dot_int_acc: driver pushes expected group results, monitor pops on handshake.
module tb_dot_int_acc;
  localparam int BW = 8;
  localparam int K  = 32;
  localparam int AE = 8;
  localparam int AW = 2*BW + $clog2(K) + AE;
  localparam longint AMAX = (longint'(1) << (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW-1));
  localparam longint AMOD = longint'(1) << AW;

  typedef logic [K-1:0][BW-1:0] vec_t;
  typedef struct { longint acc; int cnt; bit ovf; } res_t;

  logic clk, rst;
  vec_t i_vec_a, i_vec_b;
  logic i_valid, i_last, i_ready;
  logic signed [AW-1:0] o_acc;
  logic [15:0] o_cnt;
  logic o_ovf, o_valid, o_ready;

  dot_int_acc #(.bit_width(BW), .k(K), .acc_ext(AE)) dut (
    .clk(clk), .rst(rst), .i_vec_a(i_vec_a), .i_vec_b(i_vec_b),
    .i_valid(i_valid), .i_last(i_last), .i_ready(i_ready),
    .o_acc(o_acc), .o_cnt(o_cnt), .o_ovf(o_ovf),
    .o_valid(o_valid), .o_ready(o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  res_t exp_q[$];
  int rmode = 0;  // 0: o_ready=1, 1: random, 2: o_ready=0

  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  bit     m_open = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic vec_t fill(int v);
    vec_t r;
    for (int i = 0; i < K; i++) r[i] = v[BW-1:0];
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < K; i++) r[i] = BW'($urandom);
    return r;
  endfunction

  function automatic longint dot(vec_t a, vec_t b);
    longint s = 0;
    for (int i = 0; i < K; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
    return s;
  endfunction

  task automatic model_accept(vec_t a, vec_t b, bit last, bit push);
    longint d = dot(a, b);
    longint n;
    if (!m_open) begin
      m_acc = d; m_cnt = 1; m_ovf = 1'b0;
    end else begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
`ifdef DOT_INT_ACC_SAT_EN
      if (!m_ovf) begin
        n = m_acc + d;
        if (n > AMAX)      begin m_acc = AMAX; m_ovf = 1'b1; end
        else if (n < AMIN) begin m_acc = AMIN; m_ovf = 1'b1; end
        else               m_acc = n;
      end
`else
      n = m_acc + d;
      if (n > AMAX)      begin n -= AMOD; m_ovf = 1'b1; end
      else if (n < AMIN) begin n += AMOD; m_ovf = 1'b1; end
      m_acc = n;
`endif
    end
    m_open = !last;
    if (last && push) exp_q.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf});
  endtask

  task automatic push_exp(longint acc, int cnt, bit ovf);
    exp_q.push_back('{acc: acc, cnt: cnt, ovf: ovf});
  endtask

  // Holds the pair until accepted, then drops i_valid just after the accepting edge.
  task automatic send(vec_t a, vec_t b, bit last, bit push);
    bit done = 1'b0;
    @(negedge clk);
    i_vec_a = a; i_vec_b = b; i_last = last; i_valid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      #1;
      if (i_ready) done = 1'b1;
      else @(negedge clk);
    end
    if (done) begin
      model_accept(a, b, last, push);
      @(posedge clk);
      #1;
    end else begin
      fail_now("send_timeout");
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain();
    bool_wait: for (int t = 0; t < 3000; t++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0 && !o_valid) return;
    end
    fail_now("drain_timeout");
  endtask

  initial begin
    o_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        0: o_ready = 1'b1;
        1: o_ready = ($urandom_range(0, 3) != 0);
        default: o_ready = 1'b0;
      endcase
    end
  end

  initial begin
    res_t e;
    forever begin
      @(negedge clk); #2;
      if (rst || !o_valid) continue;
      if (!o_ready) begin
        chk("stall_i_ready", longint'(i_ready), 0);
        if (exp_q.size() != 0) chk("stall_acc_hold", o_acc, exp_q[0].acc);
      end else if (exp_q.size() == 0) begin
        fail_now("unexpected_o_valid");
      end else begin
        e = exp_q.pop_front();
        chk("o_acc", o_acc, e.acc);
        chk("o_cnt", longint'(o_cnt), longint'(e.cnt));
        chk("o_ovf", longint'(o_ovf), longint'(e.ovf));
      end
    end
  end

  initial begin
    int n;
    int len;
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0;
    i_vec_a = '0; i_vec_b = '0;

    repeat (3) @(negedge clk);
    #3;
    chk("rst_o_valid", longint'(o_valid), 0);
    chk("rst_o_acc", o_acc, 0);
    chk("rst_o_cnt", longint'(o_cnt), 0);
    chk("rst_o_ovf", longint'(o_ovf), 0);
    chk("rst_i_ready", longint'(i_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // four vectors of all -128, result and latency
    for (int v = 0; v < 4; v++) send(fill(-128), fill(-128), v == 3, 1'b0);
    push_exp(2097152, 4, 1'b0);
    n = 1;
    while (!o_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_cycles", n, 3);
    drain();

    // back-to-back single-vector groups
    send(fill(1), fill(2), 1'b1, 1'b0);
    push_exp(64, 1, 1'b0);
    send(fill(3), fill(-1), 1'b1, 1'b0);
    push_exp(-96, 1, 1'b0);
    n = 0;
    while (!o_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_first", o_acc, 64);
    @(posedge clk); #1;
    chk("b2b_second_valid", longint'(o_valid), 1);
    chk("b2b_second_acc", o_acc, -96);
    drain();

    // 512 vectors of all -128: the final addition overflows
    for (int v = 0; v < 512; v++) send(fill(-128), fill(-128), v == 511, 1'b0);
`ifdef DOT_INT_ACC_SAT_EN
    push_exp(268435455, 512, 1'b1);
`else
    push_exp(-268435456, 512, 1'b1);
`endif
    drain();

    // stall: results pending with o_ready low for 5 cycles
    rmode = 2;
    o_ready = 1'b0;
    for (int v = 0; v < 3; v++) send(rand_vec(), rand_vec(), 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    rmode = 0;
    drain();

    // reset mid-group discards the partial group
    send(fill(1), fill(1), 1'b0, 1'b1);
    send(fill(1), fill(1), 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    m_open = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); #3;
      chk("post_rst_no_valid", longint'(o_valid), 0);
    end
    send(fill(1), fill(1), 1'b1, 1'b0);
    push_exp(32, 1, 1'b0);
    drain();

    // random groups of 1-8 vectors with random o_ready and input gaps
    rmode = 1;
    for (int g = 0; g < 1500; g++) begin
      len = $urandom_range(1, 8);
      for (int v = 0; v < len; v++) begin
        send(rand_vec(), rand_vec(), v == len - 1, 1'b1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
    drain();
    rmode = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
